// File: rtl/xnor_cmp_pkg.sv
// Shared definitions for the xnor_cmp_pipe block: buffer depth and occupancy type.
// The W-dependent result entry type lives in the top, because a package cannot take W.
package xnor_cmp_pkg;

    localparam int DEPTH = 2;

    typedef logic [1:0] occ_t;

    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_FULL  = 2'(DEPTH);

endpackage : xnor_cmp_pkg

// File: rtl/xnor_cmp_fifo2.sv
// Two-entry result buffer with ping-pong pointers and asynchronous reset.
// The entry type is supplied by the instantiating module.
module xnor_cmp_fifo2
    import xnor_cmp_pkg::*;
#(
    parameter type entry_t = logic [4:0]
) (
    input  logic   clk,
    input  logic   areset,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output occ_t   occ
);

    entry_t mem [DEPTH];
    logic   wr_ptr;
    logic   rd_ptr;
    logic   do_push;
    logic   do_pop;

    // Guard both sides so a stray request can never corrupt occupancy.
    assign do_push = push && (occ != OCC_FULL);
    assign do_pop  = pop && (occ != OCC_EMPTY);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= OCC_EMPTY;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule : xnor_cmp_fifo2

// File: rtl/xnor_cmp_pipe.sv
// Streaming bitwise XNOR comparator with a 2-deep result buffer.
// Optional statistics (sample/mismatch counters, first-mismatch index) under XNOR_CMP_STATS_EN.
module xnor_cmp_pipe
    import xnor_cmp_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     x,
    input  logic [W-1:0]     y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     z,
    output logic             eq,
    input  logic             clr,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             first_mm_vld,
    output logic [CNT_W-1:0] first_mm_idx
);

    typedef struct packed {
        logic [W-1:0] z;
        logic         eq;
    } entry_t;

    entry_t new_entry;
    entry_t head;
    occ_t   occ;
    logic   accept;
    logic   pop;

    // Handshake: a transfer happens on an edge where valid & ready are both high.
    // in_ready and out_valid come only from registered occupancy, so neither
    // depends on in_valid or out_ready; a full buffer refuses input even while popping.
    assign in_ready  = (occ != OCC_FULL);
    assign out_valid = (occ != OCC_EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign new_entry.z  = ~(x ^ y);
    assign new_entry.eq = (x == y);

    xnor_cmp_fifo2 #(
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .areset    (areset),
        .push      (accept),
        .push_data (new_entry),
        .pop       (pop),
        .head      (head),
        .occ       (occ)
    );

    assign z  = head.z;
    assign eq = head.eq;

`ifdef XNOR_CMP_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic mismatch;
    assign mismatch = (x != y);

    // clr wins over a concurrent accept: that sample is dropped from the statistics.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            sample_cnt   <= '0;
            mismatch_cnt <= '0;
            first_mm_vld <= 1'b0;
            first_mm_idx <= '0;
        end else if (clr) begin
            sample_cnt   <= '0;
            mismatch_cnt <= '0;
            first_mm_vld <= 1'b0;
            first_mm_idx <= '0;
        end else if (accept) begin
            if (sample_cnt != CNT_MAX) begin
                sample_cnt <= sample_cnt + 1'b1;
            end
            if (mismatch) begin
                if (mismatch_cnt != CNT_MAX) begin
                    mismatch_cnt <= mismatch_cnt + 1'b1;
                end
                if (!first_mm_vld) begin
                    first_mm_vld <= 1'b1;
                    first_mm_idx <= sample_cnt;
                end
            end
        end
    end
`else
    logic unused_clr;
    assign unused_clr   = clr;
    assign sample_cnt   = '0;
    assign mismatch_cnt = '0;
    assign first_mm_vld = 1'b0;
    assign first_mm_idx = '0;
`endif

endmodule : xnor_cmp_pipe

// File: tb/tb_xnor_cmp_pipe.sv
// Self-checking bench for xnor_cmp_pipe: vector table, directed corner sequences and
// a randomized run against a queue-based reference model.
module tb_xnor_cmp_pipe;

    localparam int W       = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef XNOR_CMP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk;
    logic             areset;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     x;
    logic [W-1:0]     y;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     z;
    logic             eq;
    logic             clr;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] mismatch_cnt;
    logic             first_mm_vld;
    logic [CNT_W-1:0] first_mm_idx;

    xnor_cmp_pipe #(
        .W     (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .areset       (areset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .x            (x),
        .y            (y),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .z            (z),
        .eq           (eq),
        .clr          (clr),
        .sample_cnt   (sample_cnt),
        .mismatch_cnt (mismatch_cnt),
        .first_mm_vld (first_mm_vld),
        .first_mm_idx (first_mm_idx)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / model ----------------
    logic [W:0]   exp_q[$];   // {z, eq} results not yet popped, oldest first
    logic [W-1:0] got_q[$];   // z values actually popped from the DUT
    int           m_samples;
    int           m_mism;
    bit           m_first_vld;
    int           m_first_idx;
    int           n_cmp;
    int           n_err;
    int           n_acc;

    function automatic int stat_exp(input int v);
        return STATS ? v : 0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_samples   = 0;
        m_mism      = 0;
        m_first_vld = 1'b0;
        m_first_idx = 0;
    endtask

    task automatic check_outputs();
        check("out_valid", out_valid, exp_q.size() != 0);
        check("in_ready", in_ready, exp_q.size() < 2);
        if (exp_q.size() != 0) begin
            check("z", z, exp_q[0][W:1]);
            check("eq", eq, exp_q[0][0]);
        end
        check("sample_cnt", sample_cnt, stat_exp(m_samples));
        check("mismatch_cnt", mismatch_cnt, stat_exp(m_mism));
        check("first_mm_vld", first_mm_vld, stat_exp(m_first_vld));
        check("first_mm_idx", first_mm_idx, stat_exp(m_first_idx));
    endtask

    // ---------------- driver ----------------
    // Called at edge+1: drives one cycle of inputs, checks outputs, advances the model.
    task automatic cycle(input logic iv, input logic [W-1:0] xv, input logic [W-1:0] yv,
                         input logic ordy, input logic cv);
        bit acc;
        bit pp;
        in_valid  = iv;
        x         = xv;
        y         = yv;
        out_ready = ordy;
        clr       = cv;
        check_outputs();
        acc = iv && (exp_q.size() < 2);
        pp  = ordy && (exp_q.size() != 0);
        if (out_valid && out_ready) got_q.push_back(z);
        @(posedge clk);
        #1;
        if (pp) void'(exp_q.pop_front());
        if (acc) begin
            exp_q.push_back({~(xv ^ yv), xv == yv});
            n_acc++;
        end
        if (cv) begin
            m_samples   = 0;
            m_mism      = 0;
            m_first_vld = 1'b0;
            m_first_idx = 0;
        end else if (acc) begin
            if (xv != yv) begin
                if (!m_first_vld) begin
                    m_first_vld = 1'b1;
                    m_first_idx = m_samples;
                end
                m_mism = (m_mism < CNT_MAX) ? m_mism + 1 : m_mism;
            end
            m_samples = (m_samples < CNT_MAX) ? m_samples + 1 : m_samples;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    // ---------------- test ----------------
    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] z;
        logic         eq;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int got_base;
        int cyc;
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        logic [W-1:0] iw;

        tbl[0] = '{x: 4'h0, y: 4'h0, z: 4'hF, eq: 1'b1};
        tbl[1] = '{x: 4'h1, y: 4'h0, z: 4'hE, eq: 1'b0};
        tbl[2] = '{x: 4'h2, y: 4'h0, z: 4'hD, eq: 1'b0};
        tbl[3] = '{x: 4'h3, y: 4'h0, z: 4'hC, eq: 1'b0};

        n_cmp = 0;
        n_err = 0;
        n_acc = 0;
        model_reset();
        areset    = 1'b1;
        in_valid  = 1'b0;
        x         = '0;
        y         = '0;
        out_ready = 1'b0;
        clr       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        areset = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_z", z, '0);
        check("rst_sample_cnt", sample_cnt, '0);

        // Vector table: one result per cycle, latency 1
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, tbl[i].x, tbl[i].y, 1'b1, 1'b0);
            check("tbl_out_valid", out_valid, 1'b1);
            check("tbl_z", z, tbl[i].z);
            check("tbl_eq", eq, tbl[i].eq);
        end
        idle(1);
        check("tbl_sample_cnt", sample_cnt, stat_exp(4));
        check("tbl_mismatch_cnt", mismatch_cnt, stat_exp(3));
        check("tbl_first_mm_vld", first_mm_vld, stat_exp(1));
        check("tbl_first_mm_idx", first_mm_idx, stat_exp(1));

        // Back-pressure: third pair stalls, all three delivered in order
        got_base = got_q.size();
        cycle(1'b1, 4'h7, 4'h7, 1'b0, 1'b0);
        cycle(1'b1, 4'h9, 4'h1, 1'b0, 1'b0);
        check("bp_in_ready_low", in_ready, 1'b0);
        check("bp_z_hold0", z, 4'hF);
        cycle(1'b1, 4'hA, 4'h5, 1'b0, 1'b0);
        check("bp_z_hold1", z, 4'hF);
        check("bp_in_ready_still_low", in_ready, 1'b0);
        cycle(1'b1, 4'hA, 4'h5, 1'b1, 1'b0);
        check("bp_in_ready_after_pop", in_ready, 1'b1);
        cycle(1'b1, 4'hA, 4'h5, 1'b1, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        idle(1);
        check("bp_pop_count", got_q.size() - got_base, 3);
        if (got_q.size() - got_base == 3) begin
            check("bp_order0", got_q[got_base], 4'hF);
            check("bp_order1", got_q[got_base + 1], 4'h7);
            check("bp_order2", got_q[got_base + 2], 4'h0);
        end

        // clr concurrent with an accept of a mismatching pair
        cycle(1'b1, 4'h5, 4'h3, 1'b1, 1'b1);
        check("clr_sample_cnt", sample_cnt, '0);
        check("clr_mismatch_cnt", mismatch_cnt, '0);
        check("clr_first_mm_vld", first_mm_vld, 1'b0);
        check("clr_first_mm_idx", first_mm_idx, '0);
        check("clr_out_valid", out_valid, 1'b1);
        check("clr_z", z, 4'h9);
        idle(1);

        // Saturation with CNT_W = 4
        cycle(1'b0, '0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            iw = W'(i);
            cycle(1'b1, iw, ~iw, 1'b1, 1'b0);
        end
        idle(1);
        check("sat_sample_cnt", sample_cnt, stat_exp(15));
        check("sat_mismatch_cnt", mismatch_cnt, stat_exp(15));
        check("sat_first_mm_vld", first_mm_vld, stat_exp(1));
        check("sat_first_mm_idx", first_mm_idx, stat_exp(0));

        // Asynchronous reset with the buffer full
        cycle(1'b1, 4'h1, 4'h2, 1'b0, 1'b0);
        cycle(1'b1, 4'h3, 4'h3, 1'b0, 1'b0);
        check("ar_pre_full", in_ready, 1'b0);
        in_valid = 1'b0;
        #2;
        areset = 1'b1;
        #1;
        check("ar_out_valid", out_valid, 1'b0);
        check("ar_in_ready", in_ready, 1'b1);
        check("ar_z", z, '0);
        check("ar_eq", eq, 1'b0);
        check("ar_sample_cnt", sample_cnt, '0);
        check("ar_mismatch_cnt", mismatch_cnt, '0);
        check("ar_first_mm_vld", first_mm_vld, 1'b0);
        check("ar_first_mm_idx", first_mm_idx, '0);
        model_reset();
        @(negedge clk);
        areset = 1'b0;
        @(posedge clk);
        #1;

        // Randomized run with stalls and occasional clr
        n_acc = 0;
        cyc   = 0;
        while (n_acc < 200 && cyc < 3000) begin
            rx = W'($urandom_range(0, (1 << W) - 1));
            ry = ($urandom_range(0, 3) == 0) ? rx : W'($urandom_range(0, (1 << W) - 1));
            cycle($urandom_range(0, 3) != 0, rx, ry, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 39) == 0);
            cyc++;
        end
        check("rand_accepts", n_acc, 200);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 10) begin
            cycle(1'b0, '0, '0, 1'b1, 1'b0);
            cyc++;
        end
        check("rand_drained", out_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_xnor_cmp_pipe
